aes128_inv_keyschedule: RTL and testbench

Reverse-order AES-128 round-key generator for the decryption datapath. It is loaded with the round-10 key that the forward key schedule produces. It then regenerates and streams round keys 10, 9, … 0 one at a time over a valid/ready handshake, so the inverse cipher gets keys on the fly in the order it uses them, without an 11-entry key store. It sits between the key-load path and the iterative AES-128 decryption round core.

---
 rtl/aes128_inv_keyschedule_if.sv | 24 ++
 rtl/aes128_inv_keyschedule.sv | 131 +++++++++++++
 tb/tb_aes128_inv_keyschedule.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/aes128_inv_keyschedule_if.sv
// Handshake bundle between the key-load path, the reverse key schedule and the decryption round core.
interface aes128_inv_keyschedule_if;
  localparam int unsigned KEY_W   = 128;
  localparam int unsigned ROUND_W = 4;

  logic               i_start;
  logic [KEY_W-1:0]   i_key;
  logic [KEY_W-1:0]   o_round_key;
  logic [ROUND_W-1:0] o_round;
  logic               o_valid;
  logic               i_ready;
  logic               o_busy;
  logic               o_done;

  modport slave (
    input  i_start, i_key, i_ready,
    output o_round_key, o_round, o_valid, o_busy, o_done
  );

  modport master (
    output i_start, i_key, i_ready,
    input  o_round_key, o_round, o_valid, o_busy, o_done
  );
endinterface

// File: rtl/aes128_inv_keyschedule.sv
// AES-128 reverse key schedule: loaded with the round-10 key, streams round keys 10 down to 0.
module aes128_inv_keyschedule (
  input  logic                          i_clk,
  input  logic                          i_rst,
  aes128_inv_keyschedule_if.slave       ks
);
  localparam int unsigned KEY_W   = 128;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned ROUND_W = 4;
  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(10);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  // Byte x of the table sits at bit offset 8*(255-x) since entry 0 is the MSB byte.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [10:0] idx;
    idx = {~x, 3'b000};
    return SBOX[idx +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [ROUND_W-1:0] r);
    logic [7:0] c;
    case (r)
      4'd1:    c = 8'h01;
      4'd2:    c = 8'h02;
      4'd3:    c = 8'h04;
      4'd4:    c = 8'h08;
      4'd5:    c = 8'h10;
      4'd6:    c = 8'h20;
      4'd7:    c = 8'h40;
      4'd8:    c = 8'h80;
      4'd9:    c = 8'h1b;
      4'd10:   c = 8'h36;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  state_e             state_q, state_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic [ROUND_W-1:0] round_q, round_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [WORD_W-1:0]  w0, w1, w2, w3;
  logic [WORD_W-1:0]  w1_prev, w2_prev, w3_prev, w0_prev;
  logic [WORD_W-1:0]  rot_word, sub_word;
  logic [KEY_W-1:0]   prev_key;

  // Undo one forward expansion step: recover round r-1 from round r.
  always_comb begin
    {w0, w1, w2, w3} = key_q;
    w3_prev  = w3 ^ w2;
    w2_prev  = w2 ^ w1;
    w1_prev  = w1 ^ w0;
    rot_word = {w3_prev[23:0], w3_prev[31:24]};
    w0_prev  = w0 ^ sub_word ^ {rcon(round_q), 24'h0};
    prev_key = {w0_prev, w1_prev, w2_prev, w3_prev};
  end

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    assign sub_word[8*g +: 8] = sbox(rot_word[8*g +: 8]);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      key_q   <= '0;
      round_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    case (state_q)
      S_IDLE: begin
        if (ks.i_start) begin
          key_d   = ks.i_key;
          round_d = LAST_ROUND;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (ks.i_ready) begin
          if (round_q == '0) begin
            state_d = S_DONE;
          end else begin
            key_d   = prev_key;
            round_d = round_q - ROUND_W'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Flags are registered from the next state so they align with key_q/round_q.
    valid_d = (state_d == S_RUN);
    busy_d  = (state_d == S_RUN);
    done_d  = (state_d == S_DONE);
  end

  assign ks.o_round_key = key_q;
  assign ks.o_round     = round_q;
  assign ks.o_valid     = valid_q;
  assign ks.o_busy      = busy_q;
  assign ks.o_done      = done_q;
endmodule

// File: tb/tb_aes128_inv_keyschedule.sv
// Directed bench for the AES-128 reverse key schedule using FIPS-197 A.1 and all-zero key vectors.
module tb_aes128_inv_keyschedule;
  localparam logic [127:0] A1_KEY    = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_R10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  localparam logic [127:0] ZERO_R1   = 128'h62636363626363636263636362636363;

  logic i_clk = 1'b0;
  logic i_rst;
  int   checks = 0;
  int   errors = 0;
  logic [127:0] a1_rk [0:10];
  logic [127:0] got   [0:10];
  int   nxfer, done_cyc, first_valid;

  aes128_inv_keyschedule_if kif ();

  aes128_inv_keyschedule dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .ks    (kif)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_run(input logic [127:0] key);
    @(negedge i_clk);
    kif.i_start = 1'b1;
    kif.i_key   = key;
  endtask

  task automatic clear_got();
    for (int r = 0; r <= 10; r++) got[r] = '0;
  endtask

  task automatic check_stream(input string tag);
    for (int r = 0; r <= 10; r++) check($sformatf("%s_rk%0d", tag, r), got[r], a1_rk[r]);
  endtask

  // Consumer: mode 0 = always ready, mode 1 = random ready with 5-cycle stalls at rounds 10 and 0.
  task automatic consume(input int mode, input bit hold_start, input bit inject,
                         output int n_xfer, output int d_cyc, output int f_valid);
    int exp_round, cyc, stall, last_round;
    bit stalled, inj_done, inj_clear, rdy;
    logic [127:0] held_key;
    logic [3:0]   held_round;
    exp_round = 10; cyc = 0; stall = 0; last_round = -1;
    stalled = 0; inj_done = 0; inj_clear = 0; held_key = '0; held_round = '0;
    n_xfer = 0; d_cyc = -1; f_valid = -1;
    while (d_cyc < 0 && cyc < 400) begin
      @(negedge i_clk);
      cyc++;
      if (!hold_start && cyc == 1) kif.i_start = 1'b0;
      if (inj_clear) begin
        kif.i_start = 1'b0;
        inj_clear   = 0;
      end
      if (kif.o_done) begin
        d_cyc = cyc;
        check("done_no_valid", 128'(kif.o_valid), 128'(0));
        check("done_after_r0", 128'(n_xfer), 128'(11));
      end else if (kif.o_valid) begin
        if (f_valid < 0) begin
          f_valid = cyc;
          check("busy_in_run", 128'(kif.o_busy), 128'(1));
        end
        if (stalled) begin
          check("stall_key", kif.o_round_key, held_key);
          check("stall_round", 128'(kif.o_round), 128'(held_round));
        end
        if (int'(kif.o_round) != last_round) stall = 0;
        last_round = int'(kif.o_round);
        if (mode == 0) rdy = 1'b1;
        else if ((kif.o_round == 4'd10 || kif.o_round == 4'd0) && stall < 5) rdy = 1'b0;
        else rdy = 1'($urandom_range(0, 1));
        if (!rdy) stall++;
        if (inject && kif.o_round == 4'd6 && !inj_done) begin
          kif.i_start = 1'b1;
          kif.i_key   = ~A1_KEY;
          inj_done    = 1;
          inj_clear   = 1;
        end
        kif.i_ready = rdy;
        if (rdy) begin
          check("round_order", 128'(kif.o_round), 128'(exp_round));
          if (kif.o_round <= 4'd10) got[int'(kif.o_round)] = kif.o_round_key;
          n_xfer++;
          exp_round--;
        end
        stalled    = !rdy;
        held_key   = kif.o_round_key;
        held_round = kif.o_round;
      end
    end
    if (d_cyc < 0) check("done_timeout", 128'(0), 128'(1));
  endtask

  initial begin
    a1_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    a1_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    a1_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    a1_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    a1_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    a1_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    a1_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    a1_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    a1_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    a1_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    a1_rk[10] = A1_KEY;

    i_rst = 1'b1;
    kif.i_start = 1'b0;
    kif.i_key   = '0;
    kif.i_ready = 1'b0;
    repeat (2) @(negedge i_clk);
    check("rst_valid", 128'(kif.o_valid), 128'(0));
    check("rst_busy",  128'(kif.o_busy),  128'(0));
    check("rst_done",  128'(kif.o_done),  128'(0));
    check("rst_round", 128'(kif.o_round), 128'(0));
    check("rst_key",   kif.o_round_key,   128'(0));
    i_rst = 1'b0;
    @(negedge i_clk);
    check("idle_valid", 128'(kif.o_valid), 128'(0));

    // FIPS-197 A.1 stream, always ready
    clear_got();
    start_run(A1_KEY);
    consume(0, 0, 0, nxfer, done_cyc, first_valid);
    check("a1_first_valid", 128'(first_valid), 128'(1));
    check("a1_done_cycle", 128'(done_cyc), 128'(12));
    check("a1_xfers", 128'(nxfer), 128'(11));
    check_stream("a1");
    @(negedge i_clk);
    check("a1_done_pulse", 128'(kif.o_done), 128'(0));
    check("a1_idle_valid", 128'(kif.o_valid), 128'(0));
    check("a1_idle_busy", 128'(kif.o_busy), 128'(0));

    // All-zero cipher key
    clear_got();
    start_run(ZERO_R10);
    consume(0, 0, 0, nxfer, done_cyc, first_valid);
    check("zero_xfers", 128'(nxfer), 128'(11));
    check("zero_rk10", got[10], ZERO_R10);
    check("zero_rk1", got[1], ZERO_R1);
    check("zero_rk0", got[0], 128'(0));

    // Random backpressure with stalls at rounds 10 and 0
    clear_got();
    start_run(A1_KEY);
    consume(1, 0, 0, nxfer, done_cyc, first_valid);
    check("bp_xfers", 128'(nxfer), 128'(11));
    check_stream("bp");

    // Start pulse with another key at round 6 is ignored
    clear_got();
    start_run(A1_KEY);
    consume(0, 0, 1, nxfer, done_cyc, first_valid);
    check("inj_done_cycle", 128'(done_cyc), 128'(12));
    check_stream("inj");
    @(negedge i_clk);
    check("inj_no_restart", 128'(kif.o_valid), 128'(0));

    // Asynchronous reset at round 4
    start_run(A1_KEY);
    kif.i_ready = 1'b1;
    for (int i = 0; i < 40 && !(kif.o_valid && kif.o_round == 4'd4); i++) begin
      @(negedge i_clk);
      kif.i_start = 1'b0;
    end
    check("rst_reach_r4", 128'(kif.o_round), 128'(4));
    #2 i_rst = 1'b1;
    #1;
    check("arst_valid", 128'(kif.o_valid), 128'(0));
    check("arst_busy",  128'(kif.o_busy),  128'(0));
    check("arst_round", 128'(kif.o_round), 128'(0));
    check("arst_key",   kif.o_round_key,   128'(0));
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      check("arst_no_done", 128'(kif.o_done), 128'(0));
    end
    i_rst = 1'b0;
    clear_got();
    start_run(A1_KEY);
    consume(0, 0, 0, nxfer, done_cyc, first_valid);
    check("rerun_done_cycle", 128'(done_cyc), 128'(12));
    check_stream("rerun");

    // Back-to-back runs with start held high
    clear_got();
    start_run(A1_KEY);
    consume(0, 1, 0, nxfer, done_cyc, first_valid);
    check("b2b1_done_cycle", 128'(done_cyc), 128'(12));
    check_stream("b2b1");
    @(negedge i_clk);
    check("b2b_gap_valid", 128'(kif.o_valid), 128'(0));
    check("b2b_gap_done",  128'(kif.o_done),  128'(0));
    clear_got();
    consume(0, 0, 0, nxfer, done_cyc, first_valid);
    check("b2b2_first_valid", 128'(first_valid), 128'(1));
    check("b2b2_done_cycle", 128'(done_cyc), 128'(12));
    check_stream("b2b2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
